// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
//
// Purpose:
//   Shares a single DATA_WIDTH-bit adder among NUM_REQ requesters. A
//   round-robin arbiter picks one valid requester per cycle. Its operands are
//   summed combinationally, and the sum is captured into a one-deep result
//   register that has a valid/ready response port.
//
// Parameters:
//   DATA_WIDTH  operand/result width in bits (default 32)
//   NUM_REQ     number of requesters; power of two, 2..8 (default 4)
//   ID_W        $clog2(NUM_REQ), requester ID width (derived, not overridable)
//
// Ports:
//   clk        system clock, rising-edge active
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester operand valid
//   req_ready  per-requester accept; one-hot or zero, forced 0 during reset
//   req_a      operand A, requester i in [i*DATA_WIDTH +: DATA_WIDTH]
//   req_b      operand B, same packing as req_a
//   rsp_valid  result register holds a valid sum
//   rsp_ready  consumer accepts the result
//   rsp_data   a+b mod 2^DATA_WIDTH
//   rsp_id     index of the requester that produced rsp_data
//   grant_cnt  (ADDER_ARB_STATS_EN only) NUM_REQ x 16-bit saturating
//              per-requester transfer counters, requester i in [i*16 +: 16]
//
// Build option:
//   ADDER_ARB_STATS_EN  when defined, adds grant_cnt and its counters.
//
// FSM states:
//   state | meaning
//   EMPTY | result register holds no valid sum (rsp_valid = 0)
//   FULL  | result register holds a valid sum waiting for rsp_ready
// -----------------------------------------------------------------------------
module adder_arbiter #(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REQ    = 4,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]               rsp_id
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         grant_cnt
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;

  logic [DATA_WIDTH-1:0] op_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] op_b [NUM_REQ];

  logic                  can_accept;
  logic                  grant_found;
  logic [ID_W-1:0]       grant_idx;
  logic [ID_W-1:0]       scan_idx;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] sum;

  // Unpack the flat operand buses into per-requester words.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      op_a[i] = req_a[i*DATA_WIDTH +: DATA_WIDTH];
      op_b[i] = req_b[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // The register can take a new sum when empty, or when the held sum is being
  // drained on this same edge (no bubble between back-to-back results).
  assign can_accept = (state_q == EMPTY) || rsp_ready;

  // Round-robin scan starting at rr_ptr. NUM_REQ is a power of two, so the
  // ID_W-bit add wraps modulo NUM_REQ without an explicit compare.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = rr_ptr_q + ID_W'(k);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // State flops are held by the async reset, so xfer need not see rst_n.
  // The ready output, however, must read 0 while reset is asserted.
  assign xfer = grant_found && can_accept;

  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[grant_idx] = rst_n;
    end
  end

  // The shared adder; the carry out is intentionally dropped.
  assign sum = op_a[grant_idx] + op_b[grant_idx];

  // Next-state / result-register logic.
  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    rr_ptr_d   = rr_ptr_q;

    case (state_q)
      EMPTY: begin
        if (xfer) begin
          state_d = FULL;
        end
      end
      FULL: begin
        // Drain and refill on the same edge keeps the state FULL.
        if (rsp_ready && !xfer) begin
          state_d = EMPTY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    // The priority pointer moves only on a transfer, so idle cycles keep it.
    if (xfer) begin
      rsp_data_d = sum;
      rsp_id_d   = grant_idx;
      rr_ptr_d   = grant_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

`ifdef ADDER_ARB_STATS_EN
  logic [15:0] grant_cnt_q [NUM_REQ];
  logic [15:0] grant_cnt_d [NUM_REQ];

  // Per-requester counters saturate at 0xFFFF instead of wrapping.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt_d[i] = grant_cnt_q[i];
      if (xfer && (grant_idx == ID_W'(i)) && (grant_cnt_q[i] != 16'hFFFF)) begin
        grant_cnt_d[i] = grant_cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        grant_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        grant_cnt_q[i] <= grant_cnt_d[i];
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt[i*16 +: 16] = grant_cnt_q[i];
    end
  end
`endif

endmodule
